// File: rtl/reg_file_scoreboard.sv
// Integer register file with two registered read ports and a busy-bit scoreboard.
// Decode issues stall on RAW/WAW hazards until the matching write-back retires the register.
module reg_file_scoreboard #(
    parameter int unsigned XLEN  = 64,
    parameter int unsigned NREGS = 32,
    parameter int unsigned AW    = 5
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            wb_en,
    input  logic [AW-1:0]   wb_rd,
    input  logic [XLEN-1:0] wb_data,
    input  logic            id_valid,
    input  logic [AW-1:0]   id_rs1,
    input  logic [AW-1:0]   id_rs2,
    input  logic [AW-1:0]   id_rd,
    input  logic            id_reg_wr,
    output logic            id_stall,
    output logic            rd_valid,
    output logic [XLEN-1:0] rs1_data,
    output logic [XLEN-1:0] rs2_data,
    output logic [AW:0]     busy_cnt
);

    logic [XLEN-1:0]  regs_q [NREGS];
    logic [NREGS-1:0] busy_q, busy_d;
    logic [NREGS-1:0] clr_vec;
    logic [NREGS-1:0] eb_vec;
    logic [AW:0]      busy_cnt_q, busy_cnt_d;
    logic             rd_valid_q, rd_valid_d;
    logic [XLEN-1:0]  rs1_q, rs1_d;
    logic [XLEN-1:0]  rs2_q, rs2_d;
    logic             accept;

    // A retiring write releases its register in the same cycle it lands.
    always_comb begin
        clr_vec = '0;
        if (wb_en) begin
            clr_vec[wb_rd] = 1'b1;
        end
        eb_vec    = busy_q & ~clr_vec;
        eb_vec[0] = 1'b0;
    end

    always_comb begin
        id_stall = id_valid && (eb_vec[id_rs1] || eb_vec[id_rs2] ||
                                (id_reg_wr && eb_vec[id_rd]));
        accept   = id_valid && !id_stall;
    end

    always_comb begin
        rd_valid_d = accept;
        rs1_d      = rs1_q;
        rs2_d      = rs2_q;
        if (accept) begin
            if (id_rs1 == '0) begin
                rs1_d = '0;
            end else if (clr_vec[id_rs1]) begin
                rs1_d = wb_data;
            end else begin
                rs1_d = regs_q[id_rs1];
            end
            if (id_rs2 == '0) begin
                rs2_d = '0;
            end else if (clr_vec[id_rs2]) begin
                rs2_d = wb_data;
            end else begin
                rs2_d = regs_q[id_rs2];
            end
        end
    end

    // Set after clear: a new issue is younger than the retiring write.
    always_comb begin
        busy_d = busy_q & ~clr_vec;
        if (accept && id_reg_wr) begin
            busy_d[id_rd] = 1'b1;
        end
        busy_d[0] = 1'b0;
        busy_cnt_d = '0;
        for (int unsigned i = 0; i < NREGS; i++) begin
            busy_cnt_d = busy_cnt_d + {{AW{1'b0}}, busy_d[i]};
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < NREGS; i++) begin
                regs_q[i] <= '0;
            end
            busy_q     <= '0;
            busy_cnt_q <= '0;
            rd_valid_q <= 1'b0;
            rs1_q      <= '0;
            rs2_q      <= '0;
        end else begin
            if (wb_en && wb_rd != '0) begin
                regs_q[wb_rd] <= wb_data;
            end
            busy_q     <= busy_d;
            busy_cnt_q <= busy_cnt_d;
            rd_valid_q <= rd_valid_d;
            rs1_q      <= rs1_d;
            rs2_q      <= rs2_d;
        end
    end

    assign rd_valid = rd_valid_q;
    assign rs1_data = rs1_q;
    assign rs2_data = rs2_q;
    assign busy_cnt = busy_cnt_q;

endmodule

// File: tb/tb_reg_file_scoreboard.sv
// Bench for reg_file_scoreboard: directed scenarios plus randomized traffic against an array model.
module tb_reg_file_scoreboard;

    localparam int XLEN = 64;
    localparam int AW   = 5;

    logic            clk;
    logic            rst_n;
    logic            wb_en;
    logic [AW-1:0]   wb_rd;
    logic [XLEN-1:0] wb_data;
    logic            id_valid;
    logic [AW-1:0]   id_rs1;
    logic [AW-1:0]   id_rs2;
    logic [AW-1:0]   id_rd;
    logic            id_reg_wr;
    logic            id_stall;
    logic            rd_valid;
    logic [XLEN-1:0] rs1_data;
    logic [XLEN-1:0] rs2_data;
    logic [AW:0]     busy_cnt;

    reg_file_scoreboard #(.XLEN(64), .NREGS(32), .AW(5)) dut (
        .clk(clk), .rst_n(rst_n),
        .wb_en(wb_en), .wb_rd(wb_rd), .wb_data(wb_data),
        .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_rd(id_rd), .id_reg_wr(id_reg_wr),
        .id_stall(id_stall), .rd_valid(rd_valid),
        .rs1_data(rs1_data), .rs2_data(rs2_data), .busy_cnt(busy_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Architectural model: register contents and the set of pending destinations.
    logic [XLEN-1:0] m_regs [32];
    logic [31:0]     m_busy;
    logic            e_stall, e_rv, obs_stall;
    logic [XLEN-1:0] e_rs1, e_rs2;
    logic [AW:0]     e_cnt;

    function automatic logic pending(input logic [AW-1:0] r);
        return (r != 0) && m_busy[r] && !(wb_en && wb_rd == r);
    endfunction

    function automatic logic [XLEN-1:0] model_read(input logic [AW-1:0] r);
        if (r == 0) return '0;
        if (wb_en && wb_rd == r) return wb_data;
        return m_regs[r];
    endfunction

    task automatic drive(input logic rn, input logic we, input logic [AW-1:0] wrd,
                         input logic [XLEN-1:0] wd, input logic iv, input logic [AW-1:0] s1,
                         input logic [AW-1:0] s2, input logic [AW-1:0] d, input logic rw);
        rst_n = rn; wb_en = we; wb_rd = wrd; wb_data = wd;
        id_valid = iv; id_rs1 = s1; id_rs2 = s2; id_rd = d; id_reg_wr = rw;
    endtask

    // Advances one clock; the model computes expectations from the inputs held across the edge.
    task automatic step();
        logic acc;
        @(negedge clk);
        obs_stall = id_stall;
        e_stall = id_valid && (pending(id_rs1) || pending(id_rs2) || (id_reg_wr && pending(id_rd)));
        if (!rst_n) begin
            for (int i = 0; i < 32; i++) m_regs[i] = '0;
            m_busy = '0;
            e_rv = 1'b0; e_rs1 = '0; e_rs2 = '0;
        end else begin
            acc  = id_valid && !e_stall;
            e_rv = acc;
            if (acc) begin
                e_rs1 = model_read(id_rs1);
                e_rs2 = model_read(id_rs2);
            end
            if (wb_en && wb_rd != 0) begin
                m_regs[wb_rd] = wb_data;
                m_busy[wb_rd] = 1'b0;
            end
            if (acc && id_reg_wr && id_rd != 0) m_busy[id_rd] = 1'b1;
        end
        e_cnt = ($countones(m_busy)) & 6'h3f;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        drive(1'b0, 1'b1, 5'd2, 64'h1234, 1'b1, 5'd1, 5'd2, 5'd3, 1'b1);
        step();
        drive(1'b0, 1'b0, 5'd0, 64'h0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0);
        step();
        checks++; if (rd_valid !== 1'b0) begin errors++; $display("FAIL reset_rv got %b exp 0", rd_valid); end
        checks++; if (busy_cnt !== 6'd0) begin errors++; $display("FAIL reset_cnt got %0d exp 0", busy_cnt); end
        checks++; if (rs1_data !== 64'd0) begin errors++; $display("FAIL reset_rs1 got %h exp 0", rs1_data); end
        drive(1'b1, 1'b0, 5'd0, 64'h0, 1'b1, 5'd5, 5'd6, 5'd0, 1'b0);
        step();
        checks++; if (obs_stall !== 1'b0) begin errors++; $display("FAIL reset_stall got %b exp 0", obs_stall); end
        checks++; if (rd_valid !== 1'b1) begin errors++; $display("FAIL reset_issue_rv got %b exp 1", rd_valid); end
        checks++; if (rs1_data !== 64'd0 || rs2_data !== 64'd0) begin
            errors++; $display("FAIL reset_issue_data got %h/%h exp 0/0", rs1_data, rs2_data); end
        checks++; if (busy_cnt !== 6'd0) begin errors++; $display("FAIL reset_issue_cnt got %0d exp 0", busy_cnt); end
    endtask

    task automatic test_write_read();
        drive(1'b1, 1'b1, 5'd3, 64'hDEAD_BEEF, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0);
        step();
        checks++; if (rd_valid !== 1'b0) begin errors++; $display("FAIL wr_idle_rv got %b exp 0", rd_valid); end
        drive(1'b1, 1'b0, 5'd0, 64'h0, 1'b1, 5'd3, 5'd0, 5'd0, 1'b0);
        step();
        checks++; if (rs1_data !== 64'hDEAD_BEEF) begin errors++; $display("FAIL wr_read got %h exp deadbeef", rs1_data); end
        checks++; if (rd_valid !== 1'b1) begin errors++; $display("FAIL wr_read_rv got %b exp 1", rd_valid); end
    endtask

    task automatic test_bypass();
        drive(1'b1, 1'b1, 5'd7, 64'h55, 1'b1, 5'd3, 5'd7, 5'd0, 1'b0);
        step();
        checks++; if (obs_stall !== 1'b0) begin errors++; $display("FAIL byp_stall got %b exp 0", obs_stall); end
        checks++; if (rs2_data !== 64'h55) begin errors++; $display("FAIL byp_rs2 got %h exp 55", rs2_data); end
        drive(1'b1, 1'b0, 5'd0, 64'h0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0);
        step();
        checks++; if (rd_valid !== 1'b0 || rs2_data !== 64'h55) begin
            errors++; $display("FAIL byp_hold got rv=%b rs2=%h exp rv=0 rs2=55", rd_valid, rs2_data); end
    endtask

    task automatic test_raw_stall();
        drive(1'b1, 1'b0, 5'd0, 64'h0, 1'b1, 5'd0, 5'd0, 5'd4, 1'b1);
        step();
        checks++; if (busy_cnt !== 6'd1) begin errors++; $display("FAIL raw_cnt got %0d exp 1", busy_cnt); end
        drive(1'b1, 1'b0, 5'd0, 64'h0, 1'b1, 5'd4, 5'd0, 5'd0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            step();
            checks++; if (obs_stall !== 1'b1 || rd_valid !== 1'b0) begin
                errors++; $display("FAIL raw_hold got stall=%b rv=%b exp stall=1 rv=0", obs_stall, rd_valid); end
        end
        drive(1'b1, 1'b1, 5'd4, 64'hA5A5_0000_1111, 1'b1, 5'd4, 5'd0, 5'd0, 1'b0);
        step();
        checks++; if (obs_stall !== 1'b0) begin errors++; $display("FAIL raw_release got %b exp 0", obs_stall); end
        checks++; if (rd_valid !== 1'b1 || rs1_data !== 64'hA5A5_0000_1111) begin
            errors++; $display("FAIL raw_data got rv=%b rs1=%h exp rv=1 rs1=a5a500001111", rd_valid, rs1_data); end
        checks++; if (busy_cnt !== 6'd0) begin errors++; $display("FAIL raw_cnt_clr got %0d exp 0", busy_cnt); end
    endtask

    task automatic test_x0();
        drive(1'b1, 1'b1, 5'd0, 64'hFFFF, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0);
        step();
        drive(1'b1, 1'b0, 5'd0, 64'h0, 1'b1, 5'd0, 5'd3, 5'd0, 1'b1);
        step();
        checks++; if (rs1_data !== 64'd0) begin errors++; $display("FAIL x0_read got %h exp 0", rs1_data); end
        checks++; if (busy_cnt !== 6'd0) begin errors++; $display("FAIL x0_cnt got %0d exp 0", busy_cnt); end
        drive(1'b1, 1'b0, 5'd0, 64'h0, 1'b1, 5'd0, 5'd0, 5'd0, 1'b1);
        step();
        checks++; if (obs_stall !== 1'b0) begin errors++; $display("FAIL x0_stall got %b exp 0", obs_stall); end
    endtask

    task automatic test_collision();
        drive(1'b1, 1'b0, 5'd0, 64'h0, 1'b1, 5'd0, 5'd0, 5'd9, 1'b1);
        step();
        checks++; if (busy_cnt !== 6'd1) begin errors++; $display("FAIL col_set got %0d exp 1", busy_cnt); end
        drive(1'b1, 1'b1, 5'd9, 64'h9999, 1'b1, 5'd0, 5'd0, 5'd9, 1'b1);
        step();
        checks++; if (obs_stall !== 1'b0) begin errors++; $display("FAIL col_stall got %b exp 0", obs_stall); end
        checks++; if (busy_cnt !== 6'd1) begin errors++; $display("FAIL col_cnt got %0d exp 1", busy_cnt); end
        drive(1'b1, 1'b0, 5'd0, 64'h0, 1'b1, 5'd9, 5'd0, 5'd0, 1'b0);
        step();
        checks++; if (obs_stall !== 1'b1) begin errors++; $display("FAIL col_busy got %b exp 1", obs_stall); end
        drive(1'b1, 1'b1, 5'd9, 64'h7777, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0);
        step();
        drive(1'b1, 1'b0, 5'd0, 64'h0, 1'b1, 5'd9, 5'd0, 5'd0, 1'b0);
        step();
        checks++; if (rs1_data !== 64'h7777 || busy_cnt !== 6'd0) begin
            errors++; $display("FAIL col_final got rs1=%h cnt=%0d exp 7777/0", rs1_data, busy_cnt); end
    endtask

    task automatic test_random();
        for (int n = 0; n < 600; n++) begin
            drive(($urandom_range(0, 99) != 0), $urandom_range(0, 1) == 1,
                  AW'($urandom_range(0, 7)), {$urandom, $urandom},
                  $urandom_range(0, 3) != 0, AW'($urandom_range(0, 7)),
                  AW'($urandom_range(0, 7)), AW'($urandom_range(0, 7)),
                  $urandom_range(0, 1) == 1);
            step();
            checks++; if (obs_stall !== e_stall) begin errors++; $display("FAIL rnd_stall n=%0d got %b exp %b", n, obs_stall, e_stall); end
            checks++; if (rd_valid !== e_rv) begin errors++; $display("FAIL rnd_rv n=%0d got %b exp %b", n, rd_valid, e_rv); end
            checks++; if (rs1_data !== e_rs1) begin errors++; $display("FAIL rnd_rs1 n=%0d got %h exp %h", n, rs1_data, e_rs1); end
            checks++; if (rs2_data !== e_rs2) begin errors++; $display("FAIL rnd_rs2 n=%0d got %h exp %h", n, rs2_data, e_rs2); end
            checks++; if (busy_cnt !== e_cnt) begin errors++; $display("FAIL rnd_cnt n=%0d got %0d exp %0d", n, busy_cnt, e_cnt); end
        end
    endtask

    initial begin
        for (int i = 0; i < 32; i++) m_regs[i] = '0;
        m_busy = '0;
        e_rs1 = '0; e_rs2 = '0; e_rv = 1'b0; e_stall = 1'b0; e_cnt = '0; obs_stall = 1'b0;
        drive(1'b0, 1'b0, 5'd0, 64'h0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0);
        test_reset();
        test_write_read();
        test_bypass();
        test_raw_stall();
        test_x0();
        test_collision();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
